sar_search_4bit: RTL and testbench
==================================

SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the search and probe width in bits (legal range 2..8).
REQ-002 Parameter SETTLE, default 0, SHALL set the extra wait cycles between a probe change and the e/g/l sample (legal range 0..7).
REQ-003 Port clk, input, 1 bit, SHALL be the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit, SHALL request a new search when sampled high in IDLE.
REQ-006 Port e, input, 1 bit, SHALL be the external comparator result probe == target.
REQ-007 Port g, input, 1 bit, SHALL be the external comparator result probe > target.
REQ-008 Port l, input, 1 bit, SHALL be the external comparator result probe < target.
REQ-009 Port probe, output, WIDTH bits, SHALL be the registered value presented to the comparator's a input.
REQ-010 Port busy, output, 1 bit, SHALL be high while in SEARCH.
REQ-011 Port done, output, 1 bit, SHALL be a single-cycle completion pulse.
REQ-012 Port found, output, 1 bit, SHALL be high, valid with done, when e was observed.
REQ-013 Port result, output, WIDTH bits, SHALL hold the matching probe value, valid with done and held until the next start.
REQ-014 Port err, output, 1 bit, SHALL flag a protocol error, valid with done.

Function
REQ-015 The FSM SHALL have two states, IDLE and SEARCH; registers lo, hi (WIDTH bits), a settle counter, and an evaluation counter.
REQ-016 In IDLE with start=1, the block SHALL set lo=0, hi=2^WIDTH-1, probe=(2^WIDTH-1)>>1, clear found/err, and enter SEARCH on that edge.
REQ-017 In SEARCH, e/g/l SHALL be sampled on the edge where the settle counter equals SETTLE; the counter resets to 0 on every probe change.
REQ-018 With SETTLE=0, one evaluation SHALL occur per clock, starting on the first edge after start is accepted.
REQ-019 On an evaluation with e=1, the block SHALL set result=probe and found=1, pulse done, and return to IDLE.
REQ-020 On an evaluation with g=1, the block SHALL set hi=probe-1 and probe=(lo+probe-1)>>1, computing the sum at WIDTH+1 bits.
REQ-021 On an evaluation with l=1, the block SHALL set lo=probe+1 and probe=(probe+1+hi)>>1, computing the sum at WIDTH+1 bits.
REQ-022 For g=1 at probe=lo, or l=1 at probe=hi (including probe=0 and probe=2^WIDTH-1), the block SHALL NOT update lo/hi; it SHALL end with found=0, err=0, done pulsed, and no wrap-around.
REQ-023 If WIDTH+1 evaluations complete without e, the block SHALL end with found=0 and err=1.
REQ-024 done SHALL be high only in the cycle after the terminating edge, which is already in IDLE; a start in that cycle SHALL be accepted.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 probe SHALL hold its last value in IDLE.

Reset
REQ-027 While rst=1, state SHALL be IDLE; probe, result, lo, and all counters SHALL be 0; hi SHALL be 2^WIDTH-1; busy, done, found, and err SHALL be 0.
REQ-028 Asserting rst mid-search SHALL abort the search immediately, with no done pulse.
REQ-029 On the first edge after rst deasserts, start SHALL be honoured.

Configuration
REQ-030 With macro SAR_ONEHOT_CHECK_EN defined, any sampled e/g/l that is not exactly one-hot SHALL terminate the search with err=1, found=0, done pulsed, and result unchanged.
REQ-031 With SAR_ONEHOT_CHECK_EN undefined, e/g/l SHALL be resolved with priority e > g > l; all-zero SHALL count as a stall evaluation that counts toward the REQ-023 limit and leaves probe unchanged.

Verification
REQ-032 WIDTH=4, SETTLE=0, target 5, start at edge E0 -> probes 7,3,5 at E1..E3; done high after E3; found=1; result=5; err=0.
REQ-033 Target 0 -> probes 7,3,1,0; found=1; result=0; and target 15 -> probes 7,11,13,14,15; found=1; result=15.
REQ-034 SETTLE=2, target 9 -> each probe held 3 cycles; probes 7,11,9; found=1; result=9; done 9 cycles after the start edge.
REQ-035 Comparator model forcing g=1 at probe 0 (target below range) -> done after the probe=0 evaluation; found=0; err=0; probe stays 0; no wrap to 15.
REQ-036 With SAR_ONEHOT_CHECK_EN defined, drive e=g=1 at the first evaluation -> done; err=1; found=0; start during busy is ignored, and rst at the second evaluation clears busy with no done pulse.

Source files
------------

// File: rtl/sar_search_4bit.sv
// sar_search_4bit: successive-approximation (binary) search driven by an
// external magnitude comparator (e: probe==target, g: probe>target,
// l: probe<target). Build option SAR_ONEHOT_CHECK_EN turns any sampled
// e/g/l that is not one-hot into a terminating error; without it the flags
// are resolved with priority e > g > l and all-zero is a stall evaluation.
module sar_search_4bit #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             e,
   input  logic             g,
   input  logic             l,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   typedef enum logic {
      S_IDLE,
      S_SEARCH
   } state_t;

   localparam logic [WIDTH-1:0] LP_MID    = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] LP_ONE_W  = WIDTH'(1);
   localparam logic [WIDTH:0]   LP_ONE_X  = (WIDTH+1)'(1);
   localparam logic [2:0]       LP_SETTLE = 3'(SETTLE);
   // evaluation index (0-based) of the last permitted evaluation
   localparam logic [3:0]       LP_LAST   = 4'(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_probe;
   logic [WIDTH-1:0] r_result;
   logic [2:0]       r_settle;
   logic [3:0]       r_evals;
   logic             r_busy;
   logic             r_done;
   logic             r_found;
   logic             r_err;

   logic             w_eval;
   logic             w_at_lo;
   logic             w_at_hi;
   logic             w_last;
   logic [WIDTH:0]   w_sum_dn;
   logic [WIDTH:0]   w_sum_up;
   logic             w_term;
   logic             w_term_err;
   logic             w_hit;
   logic             w_go_dn;
   logic             w_go_up;

   assign w_eval   = (r_state == S_SEARCH) && (r_settle == LP_SETTLE);
   assign w_at_lo  = (r_probe == r_lo);
   assign w_at_hi  = (r_probe == r_hi);
   assign w_last   = (r_evals == LP_LAST);
   // sums kept one bit wider so the midpoint never wraps
   assign w_sum_dn = {1'b0, r_lo} + {1'b0, r_probe} - LP_ONE_X;
   assign w_sum_up = {1'b0, r_probe} + LP_ONE_X + {1'b0, r_hi};

   // Decode the outcome of the current evaluation (all zero when not evaluating)
   always_comb begin
      w_term     = 1'b0;
      w_term_err = 1'b0;
      w_hit      = 1'b0;
      w_go_dn    = 1'b0;
      w_go_up    = 1'b0;
      if (w_eval) begin
`ifdef SAR_ONEHOT_CHECK_EN
         if (!$onehot({e, g, l})) begin
            w_term     = 1'b1;
            w_term_err = 1'b1;
         end else
`endif
         if (e) begin
            w_term = 1'b1;
            w_hit  = 1'b1;
         end else if ((g && w_at_lo) || (l && w_at_hi)) begin
            // interval exhausted at its edge: stop cleanly, never wrap
            w_term = 1'b1;
         end else if (w_last) begin
            w_term     = 1'b1;
            w_term_err = 1'b1;
         end else if (g) begin
            w_go_dn = 1'b1;
         end else if (l) begin
            w_go_up = 1'b1;
         end
      end
   end

   // Search FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_lo     <= '0;
         r_hi     <= '1;
         r_probe  <= '0;
         r_result <= '0;
         r_settle <= '0;
         r_evals  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_found  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_lo     <= '0;
                  r_hi     <= '1;
                  r_probe  <= LP_MID;
                  r_found  <= 1'b0;
                  r_err    <= 1'b0;
                  r_settle <= '0;
                  r_evals  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (!w_eval) begin
                  r_settle <= r_settle + 3'd1;
               end else begin
                  // every evaluation restarts the settle wait, stalls included
                  r_settle <= '0;
                  r_evals  <= r_evals + 4'd1;
                  if (w_term) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_err   <= w_term_err;
                     r_found <= w_hit;
                     r_state <= S_IDLE;
                     if (w_hit) begin
                        r_result <= r_probe;
                     end
                  end else if (w_go_dn) begin
                     r_hi    <= r_probe - LP_ONE_W;
                     r_probe <= w_sum_dn[WIDTH:1];
                  end else if (w_go_up) begin
                     r_lo    <= r_probe + LP_ONE_W;
                     r_probe <= w_sum_up[WIDTH:1];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign probe  = r_probe;
   assign busy   = r_busy;
   assign done   = r_done;
   assign found  = r_found;
   assign result = r_result;
   assign err    = r_err;

endmodule

// File: tb/tb_sar_search_4bit.sv
// tb_sar_search_4bit: scoreboard bench for sar_search_4bit, one instance with
// SETTLE=0 and one with SETTLE=2, each driven by a behavioural comparator.
`timescale 1ns/1ps
module tb_sar_search_4bit;

   localparam int M_NORM = 0;  // honest comparator against target
   localparam int M_GHI  = 1;  // target below range: always g
   localparam int M_LHI  = 2;  // target above range: always l
   localparam int M_ZERO = 3;  // no flag at all
   localparam int M_EG   = 4;  // e and g together

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst    = 1'b1;
   logic       start0 = 1'b0;
   logic       start2 = 1'b0;
   logic       e0, g0, l0, e2, g2, l2;
   logic [3:0] probe0, probe2, result0, result2;
   logic       busy0, done0, found0, err0;
   logic       busy2, done2, found2, err2;
   int         mode   = M_NORM;
   logic [3:0] target = '0;
   int         sel    = 0;

   function automatic logic [2:0] cmp(input logic [3:0] p, input int m, input logic [3:0] t);
      case (m)
         M_GHI:   cmp = 3'b010;
         M_LHI:   cmp = 3'b001;
         M_ZERO:  cmp = 3'b000;
         M_EG:    cmp = 3'b110;
         default: cmp = {p == t, p > t, p < t};
      endcase
   endfunction

   assign {e0, g0, l0} = cmp(probe0, mode, target);
   assign {e2, g2, l2} = cmp(probe2, mode, target);

   sar_search_4bit #(.WIDTH(4), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .e(e0), .g(g0), .l(l0),
      .probe(probe0), .busy(busy0), .done(done0), .found(found0),
      .result(result0), .err(err0));

   sar_search_4bit #(.WIDTH(4), .SETTLE(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .e(e2), .g(g2), .l(l2),
      .probe(probe2), .busy(busy2), .done(done2), .found(found2),
      .result(result2), .err(err2));

   logic [3:0] m_probe, m_result;
   logic       m_busy, m_done, m_found, m_err;
   assign m_probe  = (sel == 0) ? probe0  : probe2;
   assign m_result = (sel == 0) ? result0 : result2;
   assign m_busy   = (sel == 0) ? busy0   : busy2;
   assign m_done   = (sel == 0) ? done0   : done2;
   assign m_found  = (sel == 0) ? found0  : found2;
   assign m_err    = (sel == 0) ? err0    : err2;

   typedef struct {
      string tag;
      int    found;
      int    err;
      int    result;
      int    cycles;
   } exp_t;

   exp_t q_exp[$];
   int   q_probe[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   // seq holds the probe values, first one in the low nibble
   task automatic push_exp(input string tag, input int f, input int er, input int res,
                           input logic [31:0] seq, input int n, input int hold);
      exp_t x;
      for (int i = 0; i < n; i++)
         for (int h = 0; h < hold; h++)
            q_probe.push_back(int'(seq[4*i +: 4]));
      x.tag    = tag;
      x.found  = f;
      x.err    = er;
      x.result = res;
      x.cycles = n * hold;
      q_exp.push_back(x);
   endtask

   // called at a falling edge; start is seen by the next rising edge
   task automatic run(input int s, input int m, input int t);
      int   cyc;
      bit   seen;
      int   p;
      exp_t x;
      sel    = s;
      mode   = m;
      target = 4'(t);
      if (s == 0) start0 = 1'b1;
      else        start2 = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      for (int k = 0; k < 80 && !seen; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         start2 = 1'b0;
         if (m_busy) begin
            cyc++;
            if (q_probe.size() == 0) begin
               check("busy_overrun", 32'(m_busy), 32'd0);
            end else begin
               p = q_probe.pop_front();
               check("probe", 32'(m_probe), p);
            end
         end else if (m_done) begin
            seen = 1'b1;
            x = q_exp.pop_front();
            check({x.tag, "_found"},  32'(m_found),  x.found);
            check({x.tag, "_err"},    32'(m_err),    x.err);
            check({x.tag, "_result"}, 32'(m_result), x.result);
            check({x.tag, "_cycles"}, cyc,           x.cycles);
            check({x.tag, "_probes_left"}, q_probe.size(), 32'd0);
         end
      end
      if (!seen) begin
         check("done_timeout", 32'(m_done), 32'd1);
         void'(q_exp.pop_front());
         q_probe.delete();
      end
   endtask

   task automatic idle_check(input string tag, input int exp_probe);
      @(negedge clk);
      check({tag, "_done_low"}, 32'(m_done),  32'd0);
      check({tag, "_busy_low"}, 32'(m_busy),  32'd0);
      check({tag, "_probe"},    32'(m_probe), exp_probe);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy0",   32'(busy0),   32'd0);
      check("rst_done0",   32'(done0),   32'd0);
      check("rst_found0",  32'(found0),  32'd0);
      check("rst_err0",    32'(err0),    32'd0);
      check("rst_probe0",  32'(probe0),  32'd0);
      check("rst_result0", 32'(result0), 32'd0);
      check("rst_busy2",   32'(busy2),   32'd0);
      check("rst_probe2",  32'(probe2),  32'd0);
      rst = 1'b0;

      // start on the very first edge after reset release
      push_exp("t5", 1, 0, 5, 32'h537, 3, 1);
      run(0, M_NORM, 5);
      idle_check("t5_idle", 5);

      push_exp("t0", 1, 0, 0, 32'h0137, 4, 1);
      run(0, M_NORM, 0);
      idle_check("t0_idle", 0);

      push_exp("t15", 1, 0, 15, 32'hFEDB7, 5, 1);
      run(0, M_NORM, 15);
      idle_check("t15_idle", 15);

      push_exp("t6", 1, 0, 6, 32'h6537, 4, 1);
      run(0, M_NORM, 6);
      push_exp("t10", 1, 0, 10, 32'hA9B7, 4, 1);
      run(0, M_NORM, 10);

      // back-to-back: new start in the done cycle
      push_exp("t9", 1, 0, 9, 32'h9B7, 3, 1);
      run(0, M_NORM, 9);
      push_exp("t3_b2b", 1, 0, 3, 32'h37, 2, 1);
      run(0, M_NORM, 3);
      idle_check("t3_idle", 3);

      // target below range: stops at probe 0 without wrapping
      push_exp("below", 0, 0, 3, 32'h0137, 4, 1);
      run(0, M_GHI, 0);
      idle_check("below_idle", 0);
      idle_check("below_hold", 0);

      // target above range: stops at probe 15
      push_exp("above", 0, 0, 3, 32'hFEDB7, 5, 1);
      run(0, M_LHI, 0);
      idle_check("above_idle", 15);

`ifdef SAR_ONEHOT_CHECK_EN
      push_exp("zero", 0, 1, 3, 32'h7, 1, 1);
      run(0, M_ZERO, 0);
      idle_check("zero_idle", 7);
      push_exp("eg", 0, 1, 3, 32'h7, 1, 1);
      run(0, M_EG, 0);
      idle_check("eg_idle", 7);
`else
      push_exp("zero", 0, 1, 3, 32'h77777, 5, 1);
      run(0, M_ZERO, 0);
      idle_check("zero_idle", 7);
      push_exp("eg", 1, 0, 7, 32'h7, 1, 1);
      run(0, M_EG, 0);
      idle_check("eg_idle", 7);
`endif

      // start held through the search is ignored; reset aborts silently
      sel    = 0;
      mode   = M_NORM;
      target = 4'd15;
      start0 = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy0), 32'd1);
      check("abort_p1", 32'(probe0), 32'd7);
      @(negedge clk);
      start0 = 1'b0;
      check("ignore_start_probe", 32'(probe0), 32'd11);
      rst = 1'b1;
      #1;
      check("abort_busy_clr", 32'(busy0), 32'd0);
      check("abort_probe_clr", 32'(probe0), 32'd0);
      check("abort_done", 32'(done0), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done0), 32'd0);
         check("abort_idle", 32'(busy0), 32'd0);
      end
      rst = 1'b0;
      push_exp("post_rst_t5", 1, 0, 5, 32'h537, 3, 1);
      run(0, M_NORM, 5);

      // SETTLE=2: each probe held three cycles
      push_exp("s2_t9", 1, 0, 9, 32'h9B7, 3, 3);
      run(2, M_NORM, 9);
      idle_check("s2_t9_idle", 9);
      push_exp("s2_t0", 1, 0, 0, 32'h0137, 4, 3);
      run(2, M_NORM, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
